// File: rtl/sphere_column_gen_if.sv
// Request/response bundle for sphere_column_gen: request fields in, double-buffered columns out.
interface sphere_column_gen_if #(
    parameter int NUM_ROWS = 64,
    parameter int NUM_COLS = 64,
    parameter int NUM_CH   = 2,
    parameter int RGB_RES  = 9
);
    localparam int CW = $clog2(NUM_COLS);
    localparam int RW = $clog2(NUM_ROWS);

    logic                                          req_valid;
    logic                                          req_ready;
    logic [NUM_CH-1:0][CW-1:0]                     column_index;
    logic [CW-1:0]                                 center_x;
    logic [RW-1:0]                                 center_y;
    logic [RW-1:0]                                 radius;
    logic [RGB_RES-1:0]                            color;
    logic                                          mode;
    logic [NUM_CH-1:0][NUM_ROWS-1:0][RGB_RES-1:0]  columns;
    logic                                          out_valid;
    logic                                          busy;

    modport master (
        output req_valid, column_index, center_x, center_y, radius, color, mode,
        input  req_ready, columns, out_valid, busy
    );

    modport slave (
        input  req_valid, column_index, center_x, center_y, radius, color, mode,
        output req_ready, columns, out_valid, busy
    );
endinterface

// File: rtl/sphere_column_gen.sv
// Sequential sphere column renderer for the rotating POV panel: one row per cycle for all
// channels through a square/compare pipeline, presenting only complete columns.
module sphere_column_gen #(
    parameter int NUM_ROWS = 64,
    parameter int NUM_COLS = 64,
    parameter int NUM_CH   = 2,
    parameter int RGB_RES  = 9,
    parameter int SHELL_W  = 2
) (
    input  logic               clk_in,
    input  logic               rst_n_in,
    sphere_column_gen_if.slave bus
);
    localparam int CW = $clog2(NUM_COLS);
    localparam int RW = $clog2(NUM_ROWS);
    localparam int AW = ((CW > RW) ? CW : RW) + 1;
    localparam int SW = 2 * AW + 1;
    localparam logic [RW-1:0] LAST_ROW = RW'(NUM_ROWS - 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
    typedef logic [NUM_CH-1:0][NUM_ROWS-1:0][RGB_RES-1:0] cols_t;

    state_t                    state_q, state_d;
    logic [RW-1:0]             row_q, row_d;
    logic [NUM_CH-1:0][CW-1:0] col_q, col_d;
    logic [CW-1:0]             cx_q, cx_d;
    logic [RW-1:0]             cy_q, cy_d;
    logic [RGB_RES-1:0]        color_q, color_d;
    logic [SW-1:0]             r2_q, r2_d;
    logic [SW-1:0]             inner2_q, inner2_d;
    logic                      shell_q, shell_d;
    logic                      s1_valid_q, s1_valid_d;
    logic [RW-1:0]             s1_row_q, s1_row_d;
    logic [NUM_CH-1:0][SW-1:0] dx2_q, dx2_d;
    logic [SW-1:0]             dy2_q, dy2_d;
    cols_t                     work_q, work_d;
    cols_t                     columns_q, columns_d;
    logic                      out_valid_q, out_valid_d;

    logic [NUM_CH-1:0][SW-1:0] dist2;
    logic [NUM_CH-1:0]         lit;

    // Operands are zero-extended by one bit so the difference is a valid signed value.
    function automatic logic [SW-1:0] abs_diff(input logic [AW-1:0] a, input logic [AW-1:0] b);
        logic [AW-1:0] diff;
        logic [AW-1:0] mag;
        diff = a - b;
        mag  = diff[AW-1] ? -diff : diff;
        return SW'(mag);
    endfunction

    function automatic logic [SW-1:0] square(input logic [SW-1:0] m);
        return m * m;
    endfunction

    always_comb begin
        dist2 = '0;
        lit   = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            dist2[c] = dx2_q[c] + dy2_q;
            lit[c]   = (dist2[c] <= r2_q) && (!shell_q || (dist2[c] > inner2_q));
        end
    end

    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        col_d       = col_q;
        cx_d        = cx_q;
        cy_d        = cy_q;
        color_d     = color_q;
        r2_d        = r2_q;
        inner2_d    = inner2_q;
        shell_d     = shell_q;
        s1_valid_d  = 1'b0;
        s1_row_d    = s1_row_q;
        dx2_d       = dx2_q;
        dy2_d       = dy2_q;
        work_d      = work_q;
        columns_d   = columns_q;
        out_valid_d = 1'b0;

        // Stage 2 runs ahead of the state case so DRAIN can publish the row it writes.
        if (s1_valid_q) begin
            for (int c = 0; c < NUM_CH; c++) begin
                work_d[c][s1_row_q] = lit[c] ? color_q : '0;
            end
        end

        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    col_d    = bus.column_index;
                    cx_d     = bus.center_x;
                    cy_d     = bus.center_y;
                    color_d  = bus.color;
                    r2_d     = square(SW'(bus.radius));
                    shell_d  = bus.mode && (bus.radius > RW'(SHELL_W));
                    inner2_d = shell_d ? square(SW'(bus.radius) - SW'(SHELL_W)) : '0;
                    row_d    = '0;
                    state_d  = RUN;
                end
            end
            RUN: begin
                s1_valid_d = 1'b1;
                s1_row_d   = row_q;
                dy2_d      = square(abs_diff(AW'(row_q), AW'(cy_q)));
                for (int c = 0; c < NUM_CH; c++) begin
                    dx2_d[c] = square(abs_diff(AW'(col_q[c]), AW'(cx_q)));
                end
                if (row_q == LAST_ROW) begin
                    row_d   = '0;
                    state_d = DRAIN;
                end else begin
                    row_d = row_q + 1'b1;
                end
            end
            DRAIN: begin
                columns_d   = work_d;
                out_valid_d = 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q     <= IDLE;
            row_q       <= '0;
            col_q       <= '0;
            cx_q        <= '0;
            cy_q        <= '0;
            color_q     <= '0;
            r2_q        <= '0;
            inner2_q    <= '0;
            shell_q     <= 1'b0;
            s1_valid_q  <= 1'b0;
            s1_row_q    <= '0;
            dx2_q       <= '0;
            dy2_q       <= '0;
            work_q      <= '0;
            columns_q   <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            col_q       <= col_d;
            cx_q        <= cx_d;
            cy_q        <= cy_d;
            color_q     <= color_d;
            r2_q        <= r2_d;
            inner2_q    <= inner2_d;
            shell_q     <= shell_d;
            s1_valid_q  <= s1_valid_d;
            s1_row_q    <= s1_row_d;
            dx2_q       <= dx2_d;
            dy2_q       <= dy2_d;
            work_q      <= work_d;
            columns_q   <= columns_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.req_ready = (state_q == IDLE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.columns   = columns_q;
endmodule

// File: tb/tb_sphere_column_gen.sv
// Scoreboard bench for sphere_column_gen: a driver pushes model results at each accept,
// and a negedge monitor checks handshake timing, output pulses and the presented columns.
module tb_sphere_column_gen;
    localparam int NUM_ROWS = 64;
    localparam int NUM_COLS = 64;
    localparam int NUM_CH   = 2;
    localparam int RGB_RES  = 9;
    localparam int SHELL_W  = 2;
    localparam int CW       = $clog2(NUM_COLS);
    localparam int RW       = $clog2(NUM_ROWS);
    localparam int LIMIT    = 4 * (NUM_ROWS + 2);

    typedef logic [NUM_CH-1:0][NUM_ROWS-1:0][RGB_RES-1:0] cols_t;
    typedef logic [NUM_CH-1:0][CW-1:0]                    col_idx_t;

    logic clk = 1'b0;
    logic rst_n;
    int   ec = 0;
    int   checks = 0;
    int   errors = 0;

    int    acc_q[$];
    cols_t exp_q[$];
    int    acc_hist[$];
    cols_t exp_cols = '0;

    sphere_column_gen_if #(
        .NUM_ROWS(NUM_ROWS), .NUM_COLS(NUM_COLS), .NUM_CH(NUM_CH), .RGB_RES(RGB_RES)
    ) bus ();

    sphere_column_gen #(
        .NUM_ROWS(NUM_ROWS), .NUM_COLS(NUM_COLS), .NUM_CH(NUM_CH),
        .RGB_RES(RGB_RES), .SHELL_W(SHELL_W)
    ) dut (
        .clk_in   (clk),
        .rst_n_in (rst_n),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) ec <= ec + 1;

    // Sphere rule evaluated directly with integer geometry for every channel and row.
    function automatic cols_t model(input col_idx_t ci, input int cx, input int cy, input int r,
                                    input logic [RGB_RES-1:0] col, input logic m);
        cols_t res = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            for (int y = 0; y < NUM_ROWS; y++) begin
                int dx = int'(ci[c]) - cx;
                int dy = y - cy;
                int d2 = dx * dx + dy * dy;
                bit on = (d2 <= r * r);
                if (m && r > SHELL_W) on = on && (d2 > (r - SHELL_W) * (r - SHELL_W));
                if (on) res[c][y] = col;
            end
        end
        return res;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got %0h expected %0h at edge %0d", name, got, exp, ec);
        end
    endtask

    task automatic checkColumns(input cols_t got, input cols_t exp);
        checks++;
        if (got !== exp) begin
            int fc = 0;
            int fr = 0;
            bit found = 0;
            errors++;
            for (int c = 0; c < NUM_CH; c++)
                for (int y = 0; y < NUM_ROWS; y++)
                    if (!found && got[c][y] !== exp[c][y]) begin
                        found = 1; fc = c; fr = y;
                    end
            $display("[TB] FAIL columns ch%0d row%0d got %0h expected %0h at edge %0d",
                     fc, fr, got[fc][fr], exp[fc][fr], ec);
        end
    endtask

    task automatic scrambleInputs();
        for (int c = 0; c < NUM_CH; c++) bus.column_index[c] = CW'($urandom_range(0, NUM_COLS - 1));
        bus.center_x = CW'($urandom_range(0, NUM_COLS - 1));
        bus.center_y = RW'($urandom_range(0, NUM_ROWS - 1));
        bus.radius   = RW'($urandom_range(0, NUM_ROWS - 1));
        bus.color    = RGB_RES'($urandom);
        bus.mode     = 1'($urandom);
    endtask

    // Drives a request, waits (bounded) for req_ready, and records the expectation at the accept edge.
    task automatic applyStimulus(input col_idx_t ci, input logic [CW-1:0] cx, input logic [RW-1:0] cy,
                                 input logic [RW-1:0] r, input logic [RGB_RES-1:0] col,
                                 input logic m, input bit hold);
        int waited = 0;
        @(negedge clk);
        bus.column_index = ci;
        bus.center_x     = cx;
        bus.center_y     = cy;
        bus.radius       = r;
        bus.color        = col;
        bus.mode         = m;
        bus.req_valid    = 1'b1;
        while (!bus.req_ready && waited < LIMIT) begin
            @(negedge clk);
            waited++;
        end
        checks++;
        if (!bus.req_ready) begin
            errors++;
            $display("[TB] FAIL accept_timeout got ready=%0b expected ready=1 after %0d cycles",
                     bus.req_ready, waited);
            bus.req_valid = 1'b0;
            return;
        end
        acc_q.push_back(ec + 1);
        acc_hist.push_back(ec + 1);
        exp_q.push_back(model(ci, int'(cx), int'(cy), int'(r), col, m));
        @(posedge clk);
        #1;
        scrambleInputs();
        bus.req_valid = hold;
    endtask

    task automatic applyReset();
        @(negedge clk);
        rst_n         = 1'b0;
        bus.req_valid = 1'b0;
        acc_q.delete();
        exp_q.delete();
        exp_cols = '0;
        #1;
        checkOutput("rst_columns_zero", 32'(bus.columns == '0), 32'd1);
        checkOutput("rst_out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("rst_req_ready", 32'(bus.req_ready), 32'd1);
        checkOutput("rst_busy", 32'(bus.busy), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Monitor: handshake timing, out_valid pulse position and presented columns every cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            int k;
            bit have;
            bit busy_exp;
            bit ov_exp;
            k        = ec;
            have     = (acc_q.size() != 0);
            busy_exp = have && (k >= acc_q[0]) && (k <= acc_q[0] + NUM_ROWS);
            ov_exp   = have && (k == acc_q[0] + NUM_ROWS + 1);
            checkOutput("busy", 32'(bus.busy), 32'(busy_exp));
            checkOutput("req_ready", 32'(bus.req_ready), 32'(!busy_exp));
            checkOutput("out_valid", 32'(bus.out_valid), 32'(ov_exp));
            if (ov_exp) begin
                exp_cols = exp_q.pop_front();
                void'(acc_q.pop_front());
            end
            checkColumns(bus.columns, exp_cols);
        end
    end

    initial begin
        col_idx_t ci;
        int a0;
        rst_n         = 1'b0;
        bus.req_valid = 1'b0;
        scrambleInputs();
        applyReset();

        $display("[TB] filled disk r=20");
        ci[0] = CW'(32); ci[1] = CW'(12);
        applyStimulus(ci, CW'(32), RW'(32), RW'(20), 9'h1FF, 1'b0, 1'b0);

        $display("[TB] shell r=20");
        applyStimulus(ci, CW'(32), RW'(32), RW'(20), 9'h1FF, 1'b1, 1'b0);

        $display("[TB] radius zero");
        ci[0] = CW'(5); ci[1] = CW'(6);
        applyStimulus(ci, CW'(5), RW'(7), RW'(0), 9'h0A5, 1'b0, 1'b0);

        $display("[TB] held req_valid, three back-to-back requests");
        a0 = acc_hist.size();
        for (int i = 0; i < 3; i++) begin
            for (int c = 0; c < NUM_CH; c++) ci[c] = CW'($urandom_range(0, NUM_COLS - 1));
            applyStimulus(ci, CW'($urandom_range(0, NUM_COLS - 1)), RW'($urandom_range(0, NUM_ROWS - 1)),
                          RW'($urandom_range(0, NUM_ROWS - 1)), RGB_RES'($urandom), 1'($urandom), i < 2);
        end
        if (acc_hist.size() == a0 + 3) begin
            checkOutput("accept_spacing_1", 32'(acc_hist[a0 + 1] - acc_hist[a0]), 32'(NUM_ROWS + 2));
            checkOutput("accept_spacing_2", 32'(acc_hist[a0 + 2] - acc_hist[a0 + 1]), 32'(NUM_ROWS + 2));
        end else begin
            checkOutput("accept_count", 32'(acc_hist.size() - a0), 32'd3);
        end

        $display("[TB] reset 20 cycles into RUN");
        ci[0] = CW'(40); ci[1] = CW'(41);
        applyStimulus(ci, CW'(40), RW'(30), RW'(25), 9'h123, 1'b0, 1'b0);
        repeat (19) @(negedge clk);
        applyReset();
        repeat (NUM_ROWS + 4) @(negedge clk);
        applyStimulus(ci, CW'(40), RW'(30), RW'(25), 9'h123, 1'b0, 1'b0);

        $display("[TB] centre near edge, wrapped column");
        for (int c = 0; c < NUM_CH; c++) ci[c] = CW'($urandom_range(0, NUM_COLS - 1));
        applyStimulus(ci, CW'(70), RW'(63), RW'(31), 9'h155, 1'b0, 1'b0);

        $display("[TB] randomized requests");
        for (int i = 0; i < 8; i++) begin
            for (int c = 0; c < NUM_CH; c++) ci[c] = CW'($urandom_range(0, NUM_COLS - 1));
            if ($urandom_range(0, 3) == 0) ci[1] = ci[0];
            applyStimulus(ci, CW'($urandom_range(0, NUM_COLS - 1)), RW'($urandom_range(0, NUM_ROWS - 1)),
                          RW'($urandom_range(0, NUM_ROWS - 1)), RGB_RES'($urandom), 1'($urandom),
                          1'($urandom));
        end

        begin
            int w = 0;
            bus.req_valid = 1'b0;
            while (acc_q.size() != 0 && w < LIMIT) begin
                @(negedge clk);
                w++;
            end
            checkOutput("drain_pending", 32'(acc_q.size()), 32'd0);
        end
        repeat (4) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
